// File: rtl/axil_pkg.sv
// Shared AXI4-Lite definitions for the read and write handlers:
// response codes, default protection bits and the read FSM state type.
package axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [2:0] ARPROT_DEFAULT = 3'b000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } rd_state_e;

    // AXI-Lite has no exclusive access, so EXOKAY is treated as a failure too.
    function automatic logic resp_is_error(input logic [1:0] resp);
        return resp != RESP_OKAY;
    endfunction

endpackage

// File: rtl/axi_read_handler.sv
// AXI4-Lite single-beat read initiator: one outstanding read, result returned
// with a one-cycle read_valid pulse.
module axi_read_handler
    import axil_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] read_addr,
    input  logic                  start_read,
    output logic                  ready,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  read_valid,
    output logic                  read_err,
    output logic [ADDR_WIDTH-1:0] s_axil_araddr,
    output logic [2:0]            s_axil_arprot,
    output logic                  s_axil_arvalid,
    input  logic                  s_axil_arready,
    input  logic [DATA_WIDTH-1:0] s_axil_rdata,
    input  logic [1:0]            s_axil_rresp,
    input  logic                  s_axil_rvalid,
    output logic                  s_axil_rready
);

    rd_state_e             state_q, state_d;
    logic                  ready_q, ready_d;
    logic [DATA_WIDTH-1:0] read_data_q, read_data_d;
    logic                  read_valid_q, read_valid_d;
    logic                  read_err_q, read_err_d;
    logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic                  arvalid_q, arvalid_d;
    logic                  rready_q, rready_d;

    always_comb begin
        state_d      = state_q;
        ready_d      = ready_q;
        read_data_d  = read_data_q;
        read_valid_d = 1'b0;
        read_err_d   = read_err_q;
        araddr_d     = araddr_q;
        arvalid_d    = arvalid_q;
        rready_d     = rready_q;

        case (state_q)
            IDLE: begin
                if (start_read) begin
                    araddr_d  = read_addr;
                    arvalid_d = 1'b1;
                    ready_d   = 1'b0;
                    state_d   = ADDR;
                end
            end
            ADDR: begin
                if (arvalid_q && s_axil_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (rready_q && s_axil_rvalid) begin
                    read_data_d  = s_axil_rdata;
                    read_err_d   = resp_is_error(s_axil_rresp);
                    read_valid_d = 1'b1;
                    rready_d     = 1'b0;
                    ready_d      = 1'b1;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d   = IDLE;
                ready_d   = 1'b1;
                arvalid_d = 1'b0;
                rready_d  = 1'b0;
            end
        endcase
    end

    // Reset abandons any in-flight transaction; the slave is reset alongside.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            ready_q      <= 1'b1;
            read_data_q  <= '0;
            read_valid_q <= 1'b0;
            read_err_q   <= 1'b0;
            araddr_q     <= '0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            ready_q      <= ready_d;
            read_data_q  <= read_data_d;
            read_valid_q <= read_valid_d;
            read_err_q   <= read_err_d;
            araddr_q     <= araddr_d;
            arvalid_q    <= arvalid_d;
            rready_q     <= rready_d;
        end
    end

    assign ready          = ready_q;
    assign read_data      = read_data_q;
    assign read_valid     = read_valid_q;
    assign read_err       = read_err_q;
    assign s_axil_araddr  = araddr_q;
    assign s_axil_arprot  = ARPROT_DEFAULT;
    assign s_axil_arvalid = arvalid_q;
    assign s_axil_rready  = rready_q;

endmodule

// File: tb/tb_axi_read_handler.sv
// Self-checking bench for axi_read_handler: a memory-backed slave model with
// programmable AR/R wait states drives the DUT; results are checked per scenario.
module tb_axi_read_handler;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] read_addr;
    logic          start_read;
    logic          ready;
    logic [DW-1:0] read_data;
    logic          read_valid;
    logic          read_err;
    logic [AW-1:0] s_axil_araddr;
    logic [2:0]    s_axil_arprot;
    logic          s_axil_arvalid;
    logic          s_axil_arready;
    logic [DW-1:0] s_axil_rdata;
    logic [1:0]    s_axil_rresp;
    logic          s_axil_rvalid;
    logic          s_axil_rready;

    always #5 clk = ~clk;

    axi_read_handler #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk            (clk),
        .rst            (rst),
        .read_addr      (read_addr),
        .start_read     (start_read),
        .ready          (ready),
        .read_data      (read_data),
        .read_valid     (read_valid),
        .read_err       (read_err),
        .s_axil_araddr  (s_axil_araddr),
        .s_axil_arprot  (s_axil_arprot),
        .s_axil_arvalid (s_axil_arvalid),
        .s_axil_arready (s_axil_arready),
        .s_axil_rdata   (s_axil_rdata),
        .s_axil_rresp   (s_axil_rresp),
        .s_axil_rvalid  (s_axil_rvalid),
        .s_axil_rready  (s_axil_rready)
    );

    // Slave model contents: data word and response code per address.
    logic [DW-1:0] mem      [32];
    logic [1:0]    resp_mem [32];

    int tests_run    = 0;
    int tests_failed = 0;

    // Observations gathered by do_read for the calling test to judge.
    logic [AW-1:0] obs_hs_addr;
    int            obs_latency;
    int            obs_ar_cycles;
    int            obs_ar_bad;
    int            obs_r_bad;
    logic          obs_valid;
    logic          obs_ready;
    logic [DW-1:0] obs_data;
    logic          obs_err;

    // Drives one read through the slave model. Inputs change and outputs are
    // observed on the falling edge. Ends on the edge where read_valid should be high.
    task automatic do_read(input logic [AW-1:0] addr, input int ar_wait, input int r_wait,
                           input bit pre_started, input bit inject, input bit chain,
                           input logic [AW-1:0] next_addr);
        int cnt;
        bit done;
        if (!pre_started) begin
            @(negedge clk);
            start_read = 1'b1;
            read_addr  = addr;
        end
        @(negedge clk);
        start_read    = 1'b0;
        obs_latency   = 1;
        obs_ar_bad    = 0;
        obs_r_bad     = 0;
        obs_ar_cycles = 0;
        cnt  = 0;
        done = 1'b0;
        while (!done) begin
            if (s_axil_arvalid !== 1'b1 || s_axil_araddr !== addr || ready !== 1'b0 ||
                s_axil_rready !== 1'b0)
                obs_ar_bad++;
            if (cnt >= ar_wait) begin
                s_axil_arready = 1'b1;
                obs_hs_addr    = s_axil_araddr;
                done           = 1'b1;
            end else begin
                s_axil_arready = 1'b0;
            end
            if (inject && cnt == 0) begin
                start_read = 1'b1;
                read_addr  = 5'd3;
            end else begin
                start_read = 1'b0;
            end
            @(negedge clk);
            obs_latency++;
            cnt++;
        end
        obs_ar_cycles  = cnt;
        s_axil_arready = 1'b0;
        start_read     = 1'b0;
        cnt  = 0;
        done = 1'b0;
        while (!done) begin
            if (s_axil_rready !== 1'b1 || s_axil_arvalid !== 1'b0 || read_valid !== 1'b0 ||
                ready !== 1'b0)
                obs_r_bad++;
            if (cnt >= r_wait) begin
                s_axil_rvalid = 1'b1;
                s_axil_rdata  = mem[obs_hs_addr];
                s_axil_rresp  = resp_mem[obs_hs_addr];
                done          = 1'b1;
            end else begin
                s_axil_rvalid = 1'b0;
                s_axil_rdata  = $urandom;
                s_axil_rresp  = 2'($urandom);
            end
            if (inject && cnt == 0) begin
                start_read = 1'b1;
                read_addr  = 5'd3;
            end else begin
                start_read = 1'b0;
            end
            @(negedge clk);
            obs_latency++;
            cnt++;
        end
        s_axil_rvalid = 1'b0;
        start_read    = 1'b0;
        obs_valid = read_valid;
        obs_ready = ready;
        obs_data  = read_data;
        obs_err   = read_err;
        if (chain) begin
            start_read = 1'b1;
            read_addr  = next_addr;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start_read = 1'b1;
        read_addr  = 5'd9;
        repeat (2) @(negedge clk);
        start_read = 1'b0;
        tests_run++;
        if (ready !== 1'b1 || read_valid !== 1'b0 || read_err !== 1'b0 || read_data !== '0) begin
            tests_failed++;
            $display("[TB] FAIL reset_user got ready=%b valid=%b err=%b data=%h want 1 0 0 0",
                     ready, read_valid, read_err, read_data);
        end
        tests_run++;
        if (s_axil_araddr !== '0 || s_axil_arvalid !== 1'b0 || s_axil_rready !== 1'b0 ||
            s_axil_arprot !== 3'b000) begin
            tests_failed++;
            $display("[TB] FAIL reset_axi got araddr=%h arvalid=%b rready=%b arprot=%b want 0 0 0 0",
                     s_axil_araddr, s_axil_arvalid, s_axil_rready, s_axil_arprot);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        mem[1] = 32'd2345;
        resp_mem[1] = 2'b00;
        do_read(5'd1, 0, 0, 1'b0, 1'b0, 1'b0, '0);
        tests_run++;
        if (obs_valid !== 1'b1 || obs_data !== 32'd2345 || obs_err !== 1'b0 || obs_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL basic_result got valid=%b data=%0d err=%b ready=%b want 1 2345 0 1",
                     obs_valid, obs_data, obs_err, obs_ready);
        end
        tests_run++;
        if (obs_latency !== 3 || obs_hs_addr !== 5'd1 || obs_ar_bad !== 0 || obs_r_bad !== 0) begin
            tests_failed++;
            $display("[TB] FAIL basic_timing got latency=%0d hs_addr=%0d ar_bad=%0d r_bad=%0d want 3 1 0 0",
                     obs_latency, obs_hs_addr, obs_ar_bad, obs_r_bad);
        end
    endtask

    task automatic test_ar_wait();
        mem[7] = $urandom;
        resp_mem[7] = 2'b00;
        do_read(5'd7, 3, 0, 1'b0, 1'b0, 1'b0, '0);
        tests_run++;
        if (obs_ar_bad !== 0 || obs_ar_cycles !== 4 || obs_hs_addr !== 5'd7) begin
            tests_failed++;
            $display("[TB] FAIL ar_wait got ar_bad=%0d hs_cycle=%0d hs_addr=%0d want 0 4 7",
                     obs_ar_bad, obs_ar_cycles, obs_hs_addr);
        end
        tests_run++;
        if (obs_data !== mem[7] || obs_latency !== 6) begin
            tests_failed++;
            $display("[TB] FAIL ar_wait_data got data=%h latency=%0d want %h 6",
                     obs_data, obs_latency, mem[7]);
        end
    endtask

    task automatic test_r_wait();
        mem[10] = 32'hDEADBEEF;
        resp_mem[10] = 2'b00;
        do_read(5'd10, 0, 4, 1'b0, 1'b0, 1'b0, '0);
        tests_run++;
        if (obs_r_bad !== 0 || obs_latency !== 7 || obs_valid !== 1'b1 || obs_data !== 32'hDEADBEEF) begin
            tests_failed++;
            $display("[TB] FAIL r_wait got r_bad=%0d latency=%0d valid=%b data=%h want 0 7 1 deadbeef",
                     obs_r_bad, obs_latency, obs_valid, obs_data);
        end
        @(negedge clk);
        tests_run++;
        if (read_valid !== 1'b0 || read_data !== 32'hDEADBEEF) begin
            tests_failed++;
            $display("[TB] FAIL pulse_width got valid=%b data=%h want 0 deadbeef", read_valid, read_data);
        end
    endtask

    task automatic test_error();
        mem[4] = 32'h12;
        resp_mem[4] = 2'b10;
        do_read(5'd4, 1, 1, 1'b0, 1'b0, 1'b0, '0);
        tests_run++;
        if (obs_err !== 1'b1 || obs_data !== 32'h12) begin
            tests_failed++;
            $display("[TB] FAIL slverr got err=%b data=%h want 1 12", obs_err, obs_data);
        end
        mem[5] = 32'h55AA;
        resp_mem[5] = 2'b00;
        do_read(5'd5, 0, 0, 1'b0, 1'b0, 1'b0, '0);
        tests_run++;
        if (obs_err !== 1'b0 || obs_data !== 32'h55AA) begin
            tests_failed++;
            $display("[TB] FAIL err_clear got err=%b data=%h want 0 55aa", obs_err, obs_data);
        end
        mem[6] = 32'h66;
        resp_mem[6] = 2'b01;
        do_read(5'd6, 0, 0, 1'b0, 1'b0, 1'b0, '0);
        tests_run++;
        if (obs_err !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL exokay_err got err=%b want 1", obs_err);
        end
    endtask

    task automatic test_ignore_start();
        int extra;
        mem[8] = $urandom;
        resp_mem[8] = 2'b00;
        do_read(5'd8, 2, 2, 1'b0, 1'b1, 1'b0, '0);
        tests_run++;
        if (obs_hs_addr !== 5'd8 || obs_ar_bad !== 0 || obs_r_bad !== 0 || obs_data !== mem[8]) begin
            tests_failed++;
            $display("[TB] FAIL ignore_start got hs_addr=%0d ar_bad=%0d r_bad=%0d data=%h want 8 0 0 %h",
                     obs_hs_addr, obs_ar_bad, obs_r_bad, obs_data, mem[8]);
        end
        extra = 0;
        s_axil_arready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (s_axil_arvalid !== 1'b0 || ready !== 1'b1) extra++;
        end
        s_axil_arready = 1'b0;
        tests_run++;
        if (extra !== 0) begin
            tests_failed++;
            $display("[TB] FAIL extra_ar got %0d cycles with arvalid or busy, want 0", extra);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        start_read = 1'b1;
        read_addr  = 5'd9;
        @(negedge clk);
        start_read = 1'b0;
        s_axil_arready = 1'b1;
        @(negedge clk);
        s_axil_arready = 1'b0;
        tests_run++;
        if (s_axil_rready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL reach_data got rready=%b want 1", s_axil_rready);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tests_run++;
        if (ready !== 1'b1 || s_axil_arvalid !== 1'b0 || s_axil_rready !== 1'b0 ||
            read_valid !== 1'b0 || read_data !== '0) begin
            tests_failed++;
            $display("[TB] FAIL reset_mid got ready=%b arvalid=%b rready=%b valid=%b data=%h want 1 0 0 0 0",
                     ready, s_axil_arvalid, s_axil_rready, read_valid, read_data);
        end
        mem[2] = $urandom;
        resp_mem[2] = 2'b00;
        do_read(5'd2, 1, 0, 1'b0, 1'b0, 1'b0, '0);
        tests_run++;
        if (obs_valid !== 1'b1 || obs_data !== mem[2] || obs_err !== 1'b0 || obs_hs_addr !== 5'd2) begin
            tests_failed++;
            $display("[TB] FAIL after_reset got valid=%b data=%h err=%b hs_addr=%0d want 1 %h 0 2",
                     obs_valid, obs_data, obs_err, obs_hs_addr, mem[2]);
        end
    endtask

    task automatic test_back_to_back();
        mem[11] = $urandom;
        mem[12] = $urandom;
        resp_mem[11] = 2'b00;
        resp_mem[12] = 2'b11;
        do_read(5'd11, 0, 0, 1'b0, 1'b0, 1'b1, 5'd12);
        tests_run++;
        if (obs_valid !== 1'b1 || obs_ready !== 1'b1 || obs_data !== mem[11]) begin
            tests_failed++;
            $display("[TB] FAIL b2b_first got valid=%b ready=%b data=%h want 1 1 %h",
                     obs_valid, obs_ready, obs_data, mem[11]);
        end
        do_read(5'd12, 0, 0, 1'b1, 1'b0, 1'b0, '0);
        tests_run++;
        if (obs_latency !== 3 || obs_ar_bad !== 0 || obs_data !== mem[12] || obs_err !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL b2b_second got latency=%0d ar_bad=%0d data=%h err=%b want 3 0 %h 1",
                     obs_latency, obs_ar_bad, obs_data, obs_err, mem[12]);
        end
    endtask

    task automatic test_random();
        logic [AW-1:0] cur, nxt;
        bit            pre, ch;
        int            arw, rw;
        for (int i = 0; i < 32; i++) begin
            mem[i]      = $urandom;
            resp_mem[i] = 2'($urandom);
        end
        cur = AW'($urandom);
        pre = 1'b0;
        for (int i = 0; i < 25; i++) begin
            nxt = AW'($urandom);
            ch  = (i == 24) ? 1'b0 : 1'($urandom_range(0, 1));
            arw = $urandom_range(0, 4);
            rw  = $urandom_range(0, 4);
            do_read(cur, arw, rw, pre, 1'b0, ch, nxt);
            tests_run++;
            if (obs_valid !== 1'b1 || obs_data !== mem[cur] || obs_err !== (resp_mem[cur] != 2'b00) ||
                obs_latency !== 3 + arw + rw || obs_ar_bad !== 0 || obs_r_bad !== 0) begin
                tests_failed++;
                $display("[TB] FAIL random_%0d addr=%0d got valid=%b data=%h err=%b lat=%0d ar_bad=%0d r_bad=%0d want 1 %h %b %0d 0 0",
                         i, cur, obs_valid, obs_data, obs_err, obs_latency, obs_ar_bad, obs_r_bad,
                         mem[cur], resp_mem[cur] != 2'b00, 3 + arw + rw);
            end
            cur = nxt;
            pre = ch;
        end
    endtask

    initial begin
        rst            = 1'b1;
        start_read     = 1'b0;
        read_addr      = '0;
        s_axil_arready = 1'b0;
        s_axil_rvalid  = 1'b0;
        s_axil_rdata   = '0;
        s_axil_rresp   = 2'b00;
        for (int i = 0; i < 32; i++) begin
            mem[i]      = '0;
            resp_mem[i] = 2'b00;
        end
        test_reset();
        test_basic();
        test_ar_wait();
        test_r_wait();
        test_error();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        test_random();
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
